// File: rtl/vga_pkg.sv
// Shared raster timing constants for the VGA timing generator.
// Defaults give 640x480 at 60 Hz from a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_CW        = 10;

  function automatic int unsigned axis_total(input int unsigned display,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return display + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC,
                                               DEF_H_BACK);
  localparam int unsigned V_TOTAL = axis_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC,
                                               DEF_V_BACK);

  localparam int unsigned H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered visible-area and sync flags
// derived from the next-state count, so the flags line up with the count itself.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned FRONT   = DEF_H_FRONT,
  parameter int unsigned SYNC    = DEF_H_SYNC,
  parameter int unsigned BACK    = DEF_H_BACK,
  parameter bit          POL     = 1'b0,
  parameter int unsigned CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam int unsigned   TOTAL      = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam int unsigned   SYNC_START = DISPLAY + FRONT;
  localparam int unsigned   SYNC_END   = SYNC_START + SYNC;
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);

  logic [CW-1:0] count_d, count_q;
  logic          active_d, active_q;
  logic          sync_d, sync_q;
  int unsigned   count_ext;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
    count_ext = 32'(count_d);
    active_d  = (count_ext < DISPLAY);
    sync_d    = (count_ext >= SYNC_START && count_ext < SYNC_END) ? POL : ~POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      active_q <= 1'b1;
      sync_q   <= ~POL;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign count  = count_q;
  assign wrap   = (count_q == LAST);
  assign active = active_q;
  assign sync   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing for the demo pixel generator: counters, syncs, visible flag and strobes.
// The vertical axis advances only on the enabled tick that wraps the horizontal axis.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          display_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  logic h_wrap, h_active;
  logic v_wrap, v_active, v_inc;
  logic unused_v_wrap;

  assign v_inc         = ena & h_wrap;
  assign unused_v_wrap = v_wrap;

  vga_axis_counter #(
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HSYNC_POL),
    .CW      (CW)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (ena),
    .count  (hpos),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (hsync)
  );

  vga_axis_counter #(
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VSYNC_POL),
    .CW      (CW)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .inc    (v_inc),
    .count  (vpos),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (vsync)
  );

  assign display_on  = h_active & v_active;
  // Gated by ena so a stall on column 0 still yields a single strobe per advancing tick.
  assign line_start  = ena & (hpos == '0);
  assign frame_start = line_start & (vpos == '0);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster timing that drives the pixel-generation logic of tt_mathis_demo: horizontal/vertical counters, sync pulses, visible-area flag and line/frame strobes.
- Sits directly upstream of the demo's pixel generator and output mux. hsync/vsync go to uo_out, hpos/vpos/display_on feed the colour logic.
- Defaults give 640x480@60 Hz from a 25.175 MHz pixel clock. All timing is parameterised so the bench can run small rasters.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync active level (0 = active-low)
VSYNC_POL, 0, vsync active level (0 = active-low)
CW, 10, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
clk  in  1  pixel clock; sole clock
rst  in  1  synchronous, active-high reset; the top level drives it from ~rst_n
ena  in  1  pixel tick enable; counters advance only when high
hpos  out  CW  current column, 0..H_TOTAL-1
vpos  out  CW  current line, 0..V_TOTAL-1
display_on  out  1  high while hpos < H_DISPLAY and vpos < V_DISPLAY
hsync  out  1  horizontal sync at HSYNC_POL level during the sync region
vsync  out  1  vertical sync at VSYNC_POL level during the sync region
line_start  out  1  one-tick strobe at hpos == 0
frame_start  out  1  one-tick strobe at hpos == 0 and vpos == 0

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Reset (rst high at a clk edge; overrides ena):
  - hpos = 0, vpos = 0, display_on = 1.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - Reset mid-frame takes effect on the next edge. No partial-line carry-over.
- Counters, when ena is high:
  - hpos increments by 1.
  - At hpos == H_TOTAL-1, hpos wraps to 0 and vpos increments by 1.
  - At vpos == V_TOTAL-1 together with the hpos wrap, vpos wraps to 0.
  - When ena is low, all registers hold their value.
- hsync, vsync and display_on are registers computed from the next-state counter values. They are therefore cycle-aligned with hpos/vpos and glitch-free. Latency is 0 cycles relative to hpos/vpos.
- hsync active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491). vsync depends on vpos only and spans full lines.
- line_start = ena & (hpos == 0). frame_start = ena & (hpos == 0) & (vpos == 0).
  - Combinational from registers.
  - Strobes are therefore exactly one per enabled tick, even when ena stalls on column 0.
  - First frame_start is the first enabled cycle after reset release.
- No arithmetic overflow: counters are compared against TOTAL-1, never allowed to reach 2^CW.

Decomposition:
- Package vga_pkg:
  - default 640x480 timing constants;
  - CW;
  - helper constants H_TOTAL, V_TOTAL, H_SYNC_START/END, V_SYNC_START/END.
- One sub-module, vga_axis_counter (params DISPLAY/FRONT/SYNC/BACK/POL/CW; ports clk, rst, inc, count, wrap, active, sync):
  - instantiated twice, horizontal with inc = ena and vertical with inc = ena & h_wrap;
  - the top module adds the strobes and ANDs the active flags.

Test Plan:
- Reset: hold rst 3 cycles with ena=1 -> hpos=0, vpos=0, display_on=1, hsync=1, vsync=1, line_start=1, frame_start=1 on the first post-reset cycle.
- Horizontal timing, ena=1 from reset:
  - display_on drops at hpos=640;
  - hsync low exactly for hpos 656..751 (96 cycles);
  - after 800 cycles hpos=0, vpos=1, line_start pulses, frame_start stays 0.
- Vertical timing: run 420000 cycles -> vsync low for vpos 490..491 (1600 cycles), display_on=0 for all of vpos>=480, frame_start pulses once at cycle 420000 with vpos back to 0.
- ena stall: toggle ena every other cycle -> the line takes 1600 clocks, and line_start is high on exactly one clock per line.
- Reset mid-operation: assert rst at hpos=700, vpos=300 (during hsync) -> next cycle hpos=0, vpos=0, hsync=1 (inactive), counting resumes normally.
- Small raster (H 4/1/2/1, V 3/1/1/1, POL=1): verify the full 8x6 sequence cycle by cycle, hsync high at hpos 5..6 and vsync high at vpos 4.
